spi_accel_responder: RTL and testbench

SPI responder (slave) that models the accelerometer side of the 4-wire SPI link driven by spi_control. It decodes command/address bytes, serves a register map including DEVID and coherent X/Y/Z data registers, accepts configuration writes, and raises a data-ready interrupt. It is used as a synthesizable stand-in for the G-sensor in loopback builds and benches. It is fed by any sample source.

---
 rtl/spi_accel_responder.sv | 206 ++++++++++++++++++++
 tb/tb_spi_accel_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/spi_accel_responder.sv
// spi_accel_responder: SPI mode-3 responder modelling an accelerometer register map
// (DEVID, rate/power/interrupt config, coherent XYZ data, data-ready interrupt).
`timescale 1ns/1ps
module spi_accel_responder #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_csn,
  input  logic        spi_sclk,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        spi_sdo_oe,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic        int1,
  output logic        measure
);

  typedef enum logic [1:0] {WAIT_DESEL, IDLE, CMD, DATA} state_t;
  typedef struct packed { logic [15:0] x, y, z; } sample_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] csn_sync, sclk_sync, sdi_sync;
  logic                   csn_s, sclk_s, sdi_s, sclk_q, sclk_rise, sclk_fall;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_shift;
  logic [7:0]             rx_byte, tx_shift;
  logic                   rw, mb, byte_done, active;
  logic [5:0]             addr, addr_nxt, load_addr;
  logic                   load_en, rd_clr, dr_set, cap_now, pend;
  logic [7:0]             bw_rate, power_ctl, int_enable, data_format;
  sample_t                shadow, pending, smp;
  logic                   dready;

  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign active    = (state == CMD) || (state == DATA);
  assign rx_byte   = {rx_shift, sdi_s};
  assign byte_done = active && !csn_s && sclk_rise && (bit_cnt == 3'd7);
  assign addr_nxt  = mb ? addr + 6'd1 : addr;
  assign measure   = power_ctl[3];
  assign smp       = '{x: sample_x, y: sample_y, z: sample_z};

  // Register read mux; data bytes come from the shadow copy, low byte first.
  function automatic logic [7:0] rd_reg(input logic [5:0] a);
    case (a)
      6'h00:   rd_reg = DEVID;
      6'h2C:   rd_reg = bw_rate;
      6'h2D:   rd_reg = power_ctl;
      6'h2E:   rd_reg = int_enable;
      6'h30:   rd_reg = {dready, 7'd0};
      6'h31:   rd_reg = data_format;
      6'h32:   rd_reg = shadow.x[7:0];
      6'h33:   rd_reg = shadow.x[15:8];
      6'h34:   rd_reg = shadow.y[7:0];
      6'h35:   rd_reg = shadow.y[15:8];
      6'h36:   rd_reg = shadow.z[7:0];
      6'h37:   rd_reg = shadow.z[15:8];
      default: rd_reg = 8'h00;
    endcase
  endfunction

  // Input synchronizers; csn resets low so a bus held selected through reset stays ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csn_sync  <= '0;
      sclk_sync <= '1;
      sdi_sync  <= '0;
      sclk_q    <= 1'b1;
    end else begin
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      sclk_q    <= sclk_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_DESEL;
    else     state <= state_n;
  end

  // Next state: deselect always returns to IDLE; command byte completes into DATA.
  always_comb begin
    state_n = state;
    if (csn_s) state_n = IDLE;
    else begin
      case (state)
        IDLE:    state_n = CMD;
        CMD:     if (byte_done) state_n = DATA;
        default: ;
      endcase
    end
  end

  // Decide when and from where the transmit byte is loaded.
  always_comb begin
    load_en   = 1'b0;
    load_addr = addr_nxt;
    if (byte_done) begin
      if (state == CMD && rx_byte[7]) begin
        load_en   = 1'b1;
        load_addr = rx_byte[5:0];
      end else if (state == DATA && rw) begin
        load_en   = 1'b1;
      end
    end
  end
  assign rd_clr = load_en && (load_addr >= 6'h32) && (load_addr <= 6'h37);

  // Shift engine: sample MOSI on rising SCLK, drive MISO on falling SCLK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      rw         <= 1'b0;
      mb         <= 1'b0;
      addr       <= '0;
      spi_sdo    <= 1'b0;
      spi_sdo_oe <= 1'b0;
    end else if (csn_s || !active) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      spi_sdo    <= 1'b0;
      spi_sdo_oe <= 1'b0;
    end else begin
      if (sclk_rise) begin
        rx_shift <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (state == CMD) begin
            rw   <= rx_byte[7];
            mb   <= rx_byte[6];
            addr <= rx_byte[5:0];
          end else begin
            addr <= addr_nxt;
          end
        end
      end
      if (load_en) begin
        tx_shift   <= rd_reg(load_addr);
        spi_sdo_oe <= 1'b1;
      end else if (sclk_fall && spi_sdo_oe) begin
        spi_sdo  <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  // Configuration registers, committed on completion of a write data byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bw_rate     <= 8'h0A;
      power_ctl   <= 8'h00;
      int_enable  <= 8'h00;
      data_format <= 8'h00;
    end else if (byte_done && state == DATA && !rw) begin
      case (addr)
        6'h2C:   bw_rate     <= rx_byte;
        6'h2D:   power_ctl   <= rx_byte;
        6'h2E:   int_enable  <= rx_byte;
        6'h31:   data_format <= rx_byte;
        default: ;
      endcase
    end
  end

  assign cap_now = measure && sample_valid && csn_s;
  assign dr_set  = cap_now || (csn_s && pend);

  // Sample capture: direct to shadow while deselected, else held pending until deselect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      pending <= '0;
      pend    <= 1'b0;
      dready  <= 1'b0;
    end else begin
      if (cap_now)            shadow <= smp;
      else if (csn_s && pend) shadow <= pending;
      if (csn_s) pend <= 1'b0;
      else if (measure && sample_valid) begin
        pending <= smp;
        pend    <= 1'b1;
      end
      if (dr_set)      dready <= 1'b1;
      else if (rd_clr) dready <= 1'b0;
    end
  end

  // Registered data-ready interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) int1 <= 1'b0;
    else     int1 <= dready & int_enable[7];
  end

endmodule

// File: tb/tb_spi_accel_responder.sv
// tb_spi_accel_responder: directed SPI transactions against hand-computed register contents.
`timescale 1ns/1ps
module tb_spi_accel_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_csn = 1'b1, spi_sclk = 1'b1, spi_sdi = 1'b0;
  logic        spi_sdo, spi_sdo_oe, int1, measure;
  logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
  logic        sample_valid = 1'b0;
  int          checks = 0, errors = 0;
  logic [7:0]  rx;
  logic        oe;
  logic [47:0] exp_b;

  spi_accel_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe), .sample_x(sample_x), .sample_y(sample_y),
    .sample_z(sample_z), .sample_valid(sample_valid), .int1(int1), .measure(measure)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // SCLK half period is 8 clk; MISO is sampled at the rising SCLK edge.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r, output logic oe_seen);
    r = '0;
    oe_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      spi_sclk = 1'b0;
      spi_sdi  = tx[7-i];
      #80;
      spi_sclk = 1'b1;
      r        = {r[6:0], spi_sdo};
      oe_seen  = oe_seen | spi_sdo_oe;
      #80;
    end
  endtask

  task automatic cs_begin();
    spi_csn = 1'b0;
    #80;
  endtask

  task automatic cs_end();
    spi_csn = 1'b1;
    #160;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] cmd, input int n, input logic [47:0] e);
    logic [7:0] r;
    logic       o;
    cs_begin();
    spi_bits(cmd, 8, r, o);
    chk({tag, "_cmd_oe"}, 16'(o), 16'd0);
    for (int i = 0; i < n; i++) begin
      spi_bits(8'h00, 8, r, o);
      chk(tag, 16'(r), 16'(e[47-8*i -: 8]));
      chk({tag, "_oe"}, 16'(o), 16'd1);
    end
    cs_end();
    chk({tag, "_oe_off"}, 16'(spi_sdo_oe), 16'd0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    logic [7:0] r;
    logic       o;
    cs_begin();
    spi_bits({2'b00, a}, 8, r, o);
    spi_bits(d, 8, r, o);
    chk("wr_oe", 16'(o), 16'd0);
    cs_end();
  endtask

  task automatic push_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    sample_x = x; sample_y = y; sample_z = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_sdo", 16'(spi_sdo), 16'd0);
    chk("rst_oe", 16'(spi_sdo_oe), 16'd0);
    chk("rst_int1", 16'(int1), 16'd0);
    chk("rst_measure", 16'(measure), 16'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // sample ignored while measure=0
    push_sample(16'h1111, 16'h2222, 16'h3333);
    rd_chk("src_off", 8'hB0, 1, {8'h00, 40'd0});
    rd_chk("devid", 8'h80, 1, {8'hE5, 40'd0});

    wr(6'h2D, 8'h08);
    chk("measure", 16'(measure), 16'd1);
    wr(6'h2E, 8'h80);
    chk("int1_idle", 16'(int1), 16'd0);
    push_sample(16'h0123, 16'hFEDC, 16'h00FF);
    @(negedge clk);
    chk("int1_set", 16'(int1), 16'd1);
    rd_chk("src_rdy", 8'hB0, 1, {8'h80, 40'd0});
    rd_chk("burst", 8'hF2, 6, 48'h2301DCFEFF00);
    chk("int1_clr", 16'(int1), 16'd0);
    rd_chk("src_clr", 8'hB0, 1, {8'h00, 40'd0});

    // sample arriving mid-burst must not tear the read
    exp_b = 48'h2301DCFEFF00;
    cs_begin();
    spi_bits(8'hF2, 8, rx, oe);
    spi_bits(8'h00, 8, rx, oe);
    chk("coh0", 16'(rx), 16'(exp_b[47:40]));
    push_sample(16'hA1B2, 16'hC3D4, 16'h0E5F);
    for (int i = 1; i < 6; i++) begin
      spi_bits(8'h00, 8, rx, oe);
      chk("coh", 16'(rx), 16'(exp_b[47-8*i -: 8]));
    end
    cs_end();
    chk("int1_pend", 16'(int1), 16'd1);
    rd_chk("src_pend", 8'hB0, 1, {8'h80, 40'd0});
    rd_chk("burst_new", 8'hF2, 6, 48'hB2A1D4C35F0E);

    rd_chk("wrap", 8'hFF, 2, {8'h00, 8'hE5, 32'd0});
    rd_chk("mb0", 8'hAC, 2, {8'h0A, 8'h0A, 32'd0});

    // reset mid-read with csn held low
    cs_begin();
    spi_bits(8'h80, 8, rx, oe);
    spi_bits(8'h00, 3, rx, oe);
    chk("pre_rst_oe", 16'(spi_sdo_oe), 16'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_sdo", 16'(spi_sdo), 16'd0);
    chk("mid_rst_oe", 16'(spi_sdo_oe), 16'd0);
    chk("mid_rst_measure", 16'(measure), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    spi_bits(8'h00, 5, rx, oe);
    chk("ign_oe0", 16'(oe), 16'd0);
    spi_bits(8'h80, 8, rx, oe);
    spi_bits(8'h00, 8, rx, oe);
    chk("ign_oe1", 16'(oe), 16'd0);
    chk("ign_rx", 16'(rx), 16'd0);
    cs_end();
    rd_chk("devid_post", 8'h80, 1, {8'hE5, 40'd0});
    rd_chk("bw_post", 8'hAC, 1, {8'h0A, 40'd0});

    // write aborted after 5 data bits is discarded
    cs_begin();
    spi_bits(8'h2E, 8, rx, oe);
    spi_bits(8'hFF, 5, rx, oe);
    cs_end();
    rd_chk("abort", 8'hAE, 1, {8'h00, 40'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
